// File: rtl/instr_fetcher_pkg.sv
// rtl/instr_fetcher_pkg.sv - shared constants, states and immediate decoders for the fetch stage
package instr_fetcher_pkg;

    localparam int ICACHE_IDX = 6;
    localparam int BHT_IDX    = 8;
    localparam logic [1:0] BHT_INIT = 2'b01;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    typedef enum logic [1:0] {
        FETCH     = 2'd0,
        MISS      = 2'd1,
        WAIT_JALR = 2'd2
    } fetch_state_t;

    function automatic logic [31:0] j_imm(input logic [31:0] ins);
        return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] b_imm(input logic [31:0] ins);
        return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/instr_fetcher_if.sv
// rtl/instr_fetcher_if.sv - decoder, ROB and memory-controller signals of the fetch stage
interface instr_fetcher_if;
    logic        rdy;
    logic        clear;
    logic [31:0] clear_pc;
    logic        full;
    logic        to_dec_ok;
    logic [31:0] to_dec_pc;
    logic [31:0] to_dec_ins;
    logic        to_dec_jp;
    logic        jalr_ok;
    logic [31:0] jalr_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_ins;
    logic        br_upd_ok;
    logic [31:0] br_upd_pc;
    logic        br_upd_taken;

    modport master (
        input  rdy, clear, clear_pc, full, jalr_ok, jalr_pc,
               mem_done, mem_ins, br_upd_ok, br_upd_pc, br_upd_taken,
        output to_dec_ok, to_dec_pc, to_dec_ins, to_dec_jp, mem_req, mem_addr
    );

    modport slave (
        output rdy, clear, clear_pc, full, jalr_ok, jalr_pc,
               mem_done, mem_ins, br_upd_ok, br_upd_pc, br_upd_taken,
        input  to_dec_ok, to_dec_pc, to_dec_ins, to_dec_jp, mem_req, mem_addr
    );
endinterface

// File: rtl/instr_fetcher_icache.sv
// rtl/instr_fetcher_icache.sv - direct-mapped one-word-per-line instruction cache
module icache
    import instr_fetcher_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:2] rd_addr,
    output logic        rd_hit,
    output logic [31:0] rd_data,
    input  logic        wr_en,
    input  logic [31:2] wr_addr,
    input  logic [31:0] wr_data
);
    localparam int LINES = 1 << ICACHE_IDX;
    localparam int TAG_W = 30 - ICACHE_IDX;

    logic [LINES-1:0]      valid;
    logic [TAG_W-1:0]      tag_mem  [LINES];
    logic [31:0]           data_mem [LINES];
    logic [ICACHE_IDX-1:0] rd_idx;
    logic [ICACHE_IDX-1:0] wr_idx;

    assign rd_idx  = rd_addr[ICACHE_IDX+1:2];
    assign wr_idx  = wr_addr[ICACHE_IDX+1:2];
    assign rd_hit  = valid[rd_idx] && (tag_mem[rd_idx] == rd_addr[31:ICACHE_IDX+2]);
    assign rd_data = data_mem[rd_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            valid <= '0;
        else if (wr_en)
            valid[wr_idx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_addr[31:ICACHE_IDX+2];
            data_mem[wr_idx] <= wr_data;
        end
    end
endmodule

// File: rtl/instr_fetcher.sv
// rtl/instr_fetcher.sv - fetch PC, icache lookup/refill, JAL/BHT next-PC prediction, JALR stall
module instr_fetcher
    import instr_fetcher_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    instr_fetcher_if.master bus
);
    localparam int BHT_SIZE = 1 << BHT_IDX;

    fetch_state_t state, state_next;
    logic [31:0]  pc, miss_addr;
    logic         out_valid, out_jp;
    logic [31:0]  out_pc, out_ins;
    logic [1:0]   bht [BHT_SIZE];

    logic         hit, consume, lookup, do_hit, do_miss, fill, jalr_done;
    logic [31:0]  hit_ins, next_pc;
    logic         next_jp;
    logic [BHT_IDX-1:0] bht_rd_idx, bht_wr_idx;
    logic         unused_upd_pc;

    icache u_icache (
        .clk     (clk),
        .rst     (rst),
        .rd_addr (pc[31:2]),
        .rd_hit  (hit),
        .rd_data (hit_ins),
        .wr_en   (fill),
        .wr_addr (miss_addr[31:2]),
        .wr_data (bus.mem_ins)
    );

    assign bus.to_dec_ok  = out_valid & ~bus.full & bus.rdy & ~bus.clear;
    assign bus.to_dec_pc  = out_pc;
    assign bus.to_dec_ins = out_ins;
    assign bus.to_dec_jp  = out_jp;
    assign bus.mem_req    = (state == MISS);
    assign bus.mem_addr   = miss_addr;

    // A presented JALR leaves the output register only once its target is known.
    assign consume   = bus.to_dec_ok & ((out_ins[6:0] != OP_JALR) | bus.jalr_ok);
    assign lookup    = bus.rdy & ~bus.clear & ~bus.full & (state == FETCH) & (~out_valid | consume);
    assign do_hit    = lookup & hit;
    assign do_miss   = lookup & ~hit;
    assign fill      = bus.rdy & (state == MISS) & bus.mem_done;
    assign jalr_done = (state == WAIT_JALR) & consume;

    assign bht_rd_idx    = pc[BHT_IDX+1:2];
    assign bht_wr_idx    = bus.br_upd_pc[BHT_IDX+1:2];
    assign unused_upd_pc = ^{bus.br_upd_pc[31:BHT_IDX+2], bus.br_upd_pc[1:0]};

    always_comb begin
        next_pc = pc + 32'd4;
        next_jp = 1'b0;
        case (hit_ins[6:0])
            OP_JAL: begin
                next_pc = pc + j_imm(hit_ins);
                next_jp = 1'b1;
            end
            OP_BRANCH: begin
                if (bht[bht_rd_idx][1]) begin
                    next_pc = pc + b_imm(hit_ins);
                    next_jp = 1'b1;
                end
            end
            OP_JALR: next_pc = pc;
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        if (bus.rdy) begin
            case (state)
                FETCH: begin
                    if (do_miss)
                        state_next = MISS;
                    else if (do_hit && hit_ins[6:0] == OP_JALR)
                        state_next = WAIT_JALR;
                end
                // The memory controller cannot be aborted, so a clear waits out the refill.
                MISS:      if (bus.mem_done) state_next = FETCH;
                WAIT_JALR: if (bus.clear || jalr_done) state_next = FETCH;
                default:   state_next = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= FETCH;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= '0;
            miss_addr <= '0;
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_ins   <= '0;
            out_jp    <= 1'b0;
        end else if (bus.rdy) begin
            if (bus.clear) begin
                out_valid <= 1'b0;
                pc        <= bus.clear_pc;
            end else begin
                if (consume)
                    out_valid <= 1'b0;
                if (do_hit) begin
                    out_valid <= 1'b1;
                    out_pc    <= pc;
                    out_ins   <= hit_ins;
                    out_jp    <= next_jp;
                    pc        <= next_pc;
                end
                if (do_miss)
                    miss_addr <= pc;
                if (jalr_done)
                    pc <= bus.jalr_pc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_SIZE; i++)
                bht[i] <= BHT_INIT;
        end else if (bus.rdy && bus.br_upd_ok) begin
            if (bus.br_upd_taken && bht[bht_wr_idx] != 2'b11)
                bht[bht_wr_idx] <= bht[bht_wr_idx] + 2'd1;
            else if (!bus.br_upd_taken && bht[bht_wr_idx] != 2'b00)
                bht[bht_wr_idx] <= bht[bht_wr_idx] - 2'd1;
        end
    end
endmodule

// File: tb/tb_instr_fetcher.sv
// tb/tb_instr_fetcher.sv - directed self-checking bench for instr_fetcher
module tb_instr_fetcher;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   resp_cnt;
    logic [31:0] mem [1024];

    instr_fetcher_if bif ();

    instr_fetcher dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory controller: answers every request three cycles after it is seen.
    initial begin
        resp_cnt     = 0;
        bif.mem_done = 1'b0;
        bif.mem_ins  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bif.mem_done) begin
                bif.mem_done = 1'b0;
                resp_cnt     = 0;
            end else if (bif.mem_req) begin
                resp_cnt++;
                if (resp_cnt == 3) begin
                    bif.mem_done = 1'b1;
                    bif.mem_ins  = mem[bif.mem_addr[11:2]];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic wait_ins(input string tag, output logic [31:0] pc, output logic [31:0] ins,
                            output logic jp, output logic seen_req);
        logic found;
        found = 1'b0; seen_req = 1'b0; pc = '0; ins = '0; jp = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            @(negedge clk);
            if (bif.mem_req) seen_req = 1'b1;
            if (bif.to_dec_ok) begin
                found = 1'b1;
                pc    = bif.to_dec_pc;
                ins   = bif.to_dec_ins;
                jp    = bif.to_dec_jp;
            end
        end
        check({tag, "_present"}, {31'd0, found}, 32'd1);
    endtask

    task automatic wait_mem(input string tag, output logic [31:0] addr);
        logic found;
        found = 1'b0; addr = '0;
        for (int i = 0; i < 80 && !found; i++) begin
            @(negedge clk);
            if (bif.mem_req) begin
                found = 1'b1;
                addr  = bif.mem_addr;
            end
        end
        check({tag, "_req"}, {31'd0, found}, 32'd1);
    endtask

    task automatic do_clear(input logic [31:0] target);
        bif.clear    = 1'b1;
        bif.clear_pc = target;
        @(negedge clk);
        bif.clear    = 1'b0;
    endtask

    logic [31:0] p, ins, a;
    logic        jp, seen;
    logic        done_seen;

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0013;
        mem[32'h000 >> 2] = 32'h0010_0093;
        mem[32'h004 >> 2] = 32'h0020_0113;
        mem[32'h008 >> 2] = 32'h0030_0193;
        mem[32'h00C >> 2] = 32'hFF5F_F06F;  // jal x0, -12
        mem[32'h010 >> 2] = 32'h0200_006F;  // jal x0, +0x20
        mem[32'h030 >> 2] = 32'h0040_0213;
        mem[32'h040 >> 2] = 32'hFE00_0CE3;  // beq x0, x0, -8
        mem[32'h050 >> 2] = 32'h0000_8067;  // jalr x0, 0(x1)
        mem[32'h060 >> 2] = 32'h0060_0313;
        mem[32'h100 >> 2] = 32'h0000_8067;
        mem[32'h200 >> 2] = 32'h0000_8067;

        rst = 1'b1;
        bif.rdy = 1'b1; bif.clear = 1'b0; bif.clear_pc = '0; bif.full = 1'b0;
        bif.jalr_ok = 1'b0; bif.jalr_pc = '0;
        bif.br_upd_ok = 1'b0; bif.br_upd_pc = '0; bif.br_upd_taken = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ok",   {31'd0, bif.to_dec_ok}, 32'd0);
        check("rst_req",  {31'd0, bif.mem_req},   32'd0);
        check("rst_addr", bif.mem_addr,           32'h0);
        check("rst_pc",   bif.to_dec_pc,          32'h0);
        check("rst_ins",  bif.to_dec_ins,         32'h0);
        check("rst_jp",   {31'd0, bif.to_dec_jp}, 32'd0);
        rst = 1'b0;

        // Cold start: each of 0x0/0x4/0x8/0xC misses and refills in order.
        wait_mem("m0", a);  check("m0_addr", a, 32'h0);
        wait_ins("i0", p, ins, jp, seen);
        check("i0_pc", p, 32'h0); check("i0_ins", ins, 32'h0010_0093); check("i0_jp", {31'd0, jp}, 32'd0);
        wait_mem("m4", a);  check("m4_addr", a, 32'h4);
        wait_ins("i4", p, ins, jp, seen);
        check("i4_pc", p, 32'h4); check("i4_jp", {31'd0, jp}, 32'd0);
        wait_mem("m8", a);  check("m8_addr", a, 32'h8);
        wait_ins("i8", p, ins, jp, seen);
        check("i8_pc", p, 32'h8); check("i8_jp", {31'd0, jp}, 32'd0);
        wait_ins("ic", p, ins, jp, seen);
        check("ic_pc", p, 32'hC); check("ic_jp", {31'd0, jp}, 32'd1);

        // Cached loop streams one instruction per cycle with no refill.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("loop_ok",  {31'd0, bif.to_dec_ok}, 32'd1);
            check("loop_pc",  bif.to_dec_pc, 32'(k * 4));
            check("loop_req", {31'd0, bif.mem_req}, 32'd0);
        end
        bif.full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("full_ok", {31'd0, bif.to_dec_ok}, 32'd0);
            check("full_pc", bif.to_dec_pc, 32'h8);
        end
        bif.full = 1'b0;
        #1;
        check("unfull_ok", {31'd0, bif.to_dec_ok}, 32'd1);
        check("unfull_pc", bif.to_dec_pc, 32'h8);
        @(negedge clk);
        check("after_full_pc", bif.to_dec_pc, 32'hC);
        check("after_full_jp", {31'd0, bif.to_dec_jp}, 32'd1);

        // JAL +0x20 from 0x10.
        do_clear(32'h10);
        wait_ins("jal", p, ins, jp, seen);
        check("jal_pc", p, 32'h10); check("jal_ins", ins, 32'h0200_006F); check("jal_jp", {31'd0, jp}, 32'd1);
        wait_ins("jal_tgt", p, ins, jp, seen);
        check("jal_tgt_pc", p, 32'h30); check("jal_tgt_jp", {31'd0, jp}, 32'd0);

        // Branch: weakly not-taken at reset, taken after two taken updates.
        do_clear(32'h40);
        wait_ins("br0", p, ins, jp, seen);
        check("br0_pc", p, 32'h40); check("br0_jp", {31'd0, jp}, 32'd0);
        wait_ins("br0_nx", p, ins, jp, seen);
        check("br0_nx_pc", p, 32'h44);
        bif.br_upd_ok = 1'b1; bif.br_upd_pc = 32'h40; bif.br_upd_taken = 1'b1;
        repeat (2) @(negedge clk);
        bif.br_upd_ok = 1'b0;
        do_clear(32'h40);
        wait_ins("br1", p, ins, jp, seen);
        check("br1_pc", p, 32'h40); check("br1_jp", {31'd0, jp}, 32'd1);
        wait_ins("br1_nx", p, ins, jp, seen);
        check("br1_nx_pc", p, 32'h38);

        // JALR holds the output until resolved.
        do_clear(32'h50);
        wait_ins("jalr", p, ins, jp, seen);
        check("jalr_pc", p, 32'h50); check("jalr_ins", ins, 32'h0000_8067); check("jalr_jp", {31'd0, jp}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("jalr_hold_ok",  {31'd0, bif.to_dec_ok}, 32'd1);
            check("jalr_hold_pc",  bif.to_dec_pc, 32'h50);
            check("jalr_hold_req", {31'd0, bif.mem_req}, 32'd0);
        end
        bif.rdy = 1'b0;
        #1;
        check("rdy_low_ok", {31'd0, bif.to_dec_ok}, 32'd0);
        @(negedge clk);
        bif.rdy = 1'b1;
        #1;
        check("rdy_back_pc", bif.to_dec_pc, 32'h50);
        bif.jalr_ok = 1'b1; bif.jalr_pc = 32'h100;
        @(negedge clk);
        bif.jalr_ok = 1'b0;
        check("jalr_taken_ok", {31'd0, bif.to_dec_ok}, 32'd0);
        wait_ins("jalr_tgt", p, ins, jp, seen);
        check("jalr_tgt_pc", p, 32'h100);

        // Clear during a refill of 0x60: refill completes, fetch restarts at 0x200.
        do_clear(32'h60);
        wait_mem("m60", a);  check("m60_addr", a, 32'h60);
        do_clear(32'h200);
        done_seen = 1'b0;
        for (int k = 0; k < 10 && !done_seen; k++) begin
            check("clr_miss_req",  {31'd0, bif.mem_req}, 32'd1);
            check("clr_miss_addr", bif.mem_addr, 32'h60);
            if (bif.mem_done) done_seen = 1'b1;
            else @(negedge clk);
        end
        check("clr_miss_done", {31'd0, done_seen}, 32'd1);
        wait_ins("clr_tgt", p, ins, jp, seen);
        check("clr_tgt_pc", p, 32'h200); check("clr_tgt_ins", ins, 32'h0000_8067);
        do_clear(32'h60);
        wait_ins("refetch60", p, ins, jp, seen);
        check("refetch60_pc",  p, 32'h60);
        check("refetch60_ins", ins, 32'h0060_0313);
        check("refetch60_req", {31'd0, seen}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
